rco_event_logger: RTL and testbench

Downstream monitor for the 4-bit `contador` counter. It watches the counter's `RCO` and `LOAD` outputs and timestamps every rising edge of either. Each event, together with the counter state at that moment, goes into a small FIFO. A consumer drains the FIFO through a valid/ready handshake. The block sits between the counter and the log/checker stage, so carry and load activity can be audited without sampling `Q` every cycle.

---
 rtl/rco_event_logger_if.sv | 12 +
 rtl/rco_event_logger.sv | 114 +++++++++++
 tb/tb_rco_event_logger.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rco_event_logger_if.sv
// Event stream from rco_event_logger to its consumer: valid/ready handshake
// carrying {TYPE, MODO, Q, TS}.
interface rco_event_logger_if #(
  parameter int TS_WIDTH = 16
);
  logic                  EV_VALID;
  logic                  EV_READY;
  logic [TS_WIDTH+7:0]   EV_DATA;

  modport master (output EV_VALID, output EV_DATA, input EV_READY);
  modport slave  (input EV_VALID, input EV_DATA, output EV_READY);
endinterface

// File: rtl/rco_event_logger.sv
// Timestamps rising edges of the counter's RCO/LOAD into a FWFT FIFO drained by valid/ready.
// Define EVLOG_DROP_CNT_EN to build the saturating DROPS counter; otherwise DROPS is tied to 0.
module rco_event_logger #(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     ENABLE,
  input  logic [3:0]               Q,
  input  logic                     RCO,
  input  logic                     LOAD,
  input  logic [1:0]               MODO,
  rco_event_logger_if.master       ev,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic [7:0]               DROPS
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TS_WIDTH + 8;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic                rco_q, load_q;
  logic                rco_rise, load_rise;
  logic                push_req, push, pop, drop;
  logic                empty, full;
  logic [TS_WIDTH-1:0] ts;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [EW-1:0]       entry;
  logic [EW-1:0]       mem [DEPTH];

  // Reset to 1 so a level already high when reset releases is not an edge.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      rco_q  <= 1'b1;
      load_q <= 1'b1;
    end else begin
      rco_q  <= RCO;
      load_q <= LOAD;
    end
  end

  always_comb begin
    rco_rise  = RCO & ~rco_q;
    load_rise = LOAD & ~load_q;
    push_req  = ENABLE & (rco_rise | load_rise);
    empty     = (count == '0);
    full      = (count == FULL_CNT);
    pop       = ~empty & ev.EV_READY;
    push      = push_req & (~full | pop);
    drop      = push_req & full & ~pop;
    entry     = {load_rise, rco_rise, MODO, Q, ts};
  end

  always_ff @(posedge clk) begin
    if (!RESET)
      ts <= '0;
    else if (ENABLE)
      ts <= ts + TS_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (RESET && push)
      mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET)
      OVERFLOW <= 1'b0;
    else if (drop)
      OVERFLOW <= 1'b1;
  end

`ifdef EVLOG_DROP_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (!RESET)
      drop_cnt <= '0;
    else if (drop && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end

  assign DROPS = drop_cnt;
`else
  assign DROPS = '0;
`endif

  assign COUNT       = count;
  assign ev.EV_VALID = ~empty;
  assign ev.EV_DATA  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_rco_event_logger.sv
// Self-checking bench for rco_event_logger: a vector table plus hand sequences and a
// random phase, all cross-checked against a queue-based scoreboard built from the event rules.
module tb_rco_event_logger;

  localparam int DEPTH    = 8;
  localparam int TS_WIDTH = 16;
  localparam int EW       = TS_WIDTH + 8;
`ifdef EVLOG_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       RESET, ENABLE, RCO, LOAD;
  logic [3:0] Q;
  logic [1:0] MODO;
  logic [3:0] COUNT;
  logic       OVERFLOW;
  logic [7:0] DROPS;

  always #5 clk = ~clk;

  rco_event_logger_if #(.TS_WIDTH(TS_WIDTH)) ev_if ();

  rco_event_logger #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .Q        (Q),
    .RCO      (RCO),
    .LOAD     (LOAD),
    .MODO     (MODO),
    .ev       (ev_if),
    .COUNT    (COUNT),
    .OVERFLOW (OVERFLOW),
    .DROPS    (DROPS)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [EW-1:0]       sb [$];
  logic [TS_WIDTH-1:0] m_ts;
  logic                m_rco_q, m_load_q, m_ovf;
  int                  m_drops;

  typedef struct {
    logic          en, rco, load, ready;
    logic [1:0]    modo;
    logic [3:0]    q;
    int            exp_count;
    logic          chk_data;
    logic [EW-1:0] exp_data;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic en, rco, load, ready, input logic [1:0] modo,
                              input logic [3:0] q, input int exp_count,
                              input logic chk_data, input logic [EW-1:0] exp_data);
    vec_t v;
    v.en = en; v.rco = rco; v.load = load; v.ready = ready;
    v.modo = modo; v.q = q; v.exp_count = exp_count;
    v.chk_data = chk_data; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle, advances the scoreboard for that edge, then checks all outputs.
  task automatic applyStimulus(input logic rst_n, en, rco, load, ready,
                               input logic [1:0] modo, input logic [3:0] q);
    logic          rr, lr;
    logic [EW-1:0] exp_head;
    RESET = rst_n; ENABLE = en; RCO = rco; LOAD = load;
    ev_if.EV_READY = ready; MODO = modo; Q = q;
    #1;
    rr = rco & ~m_rco_q;
    lr = load & ~m_load_q;
    if (!rst_n) begin
      sb.delete();
      m_ts = '0; m_rco_q = 1'b1; m_load_q = 1'b1; m_ovf = 1'b0; m_drops = 0;
    end else begin
      if ((sb.size() != 0) && ready) begin
        checkOutput("pop_data", 32'(ev_if.EV_DATA), 32'(sb[0]));
        void'(sb.pop_front());
      end
      if (en && (rr || lr)) begin
        if (sb.size() < DEPTH)
          sb.push_back({lr, rr, modo, q, m_ts});
        else begin
          m_ovf = 1'b1;
          if (m_drops != 255) m_drops++;
        end
      end
      if (en) m_ts = m_ts + 16'd1;
      m_rco_q = rco;
      m_load_q = load;
    end
    @(posedge clk);
    #1;
    exp_head = (sb.size() != 0) ? sb[0] : '0;
    checkOutput("count", 32'(COUNT), 32'(sb.size()));
    checkOutput("valid", 32'(ev_if.EV_VALID), 32'(sb.size() != 0));
    checkOutput("head_data", 32'(ev_if.EV_DATA), 32'(exp_head));
    checkOutput("overflow", 32'(OVERFLOW), 32'(m_ovf));
    checkOutput("drops", 32'(DROPS), DROP_EN ? 32'(m_drops) : 32'd0);
  endtask

  initial begin
    // Reset release with RCO high: nothing logged, timestamp runs 0..4 then event at TS=5.
    tbl[0]  = mk(1, 1, 0, 0, 2'b00, 4'd0,  0, 0, '0);
    tbl[1]  = mk(1, 1, 0, 0, 2'b00, 4'd0,  0, 0, '0);
    tbl[2]  = mk(1, 1, 0, 0, 2'b00, 4'd0,  0, 0, '0);
    tbl[3]  = mk(1, 1, 0, 0, 2'b00, 4'd0,  0, 0, '0);
    tbl[4]  = mk(1, 1, 0, 0, 2'b00, 4'd0,  0, 0, '0);
    tbl[5]  = mk(1, 1, 1, 0, 2'b01, 4'd7,  1, 1, {2'b10, 2'b01, 4'd7, 16'd5});
    tbl[6]  = mk(1, 0, 0, 1, 2'b01, 4'd7,  0, 1, '0);
    tbl[7]  = mk(1, 1, 0, 1, 2'b00, 4'd15, 1, 1, {2'b01, 2'b00, 4'd15, 16'd7});
    tbl[8]  = mk(1, 0, 0, 1, 2'b00, 4'd0,  0, 1, '0);
    tbl[9]  = mk(1, 1, 1, 0, 2'b11, 4'd4,  1, 1, {2'b11, 2'b11, 4'd4, 16'd9});
    tbl[10] = mk(1, 0, 0, 1, 2'b11, 4'd4,  0, 0, '0);
    tbl[11] = mk(0, 1, 0, 0, 2'b00, 4'd1,  0, 0, '0);
    tbl[12] = mk(0, 0, 0, 0, 2'b00, 4'd2,  0, 0, '0);
    tbl[13] = mk(1, 0, 0, 0, 2'b00, 4'd2,  0, 0, '0);
    tbl[14] = mk(1, 1, 0, 0, 2'b00, 4'd3,  1, 1, {2'b01, 2'b00, 4'd3, 16'd12});
    tbl[15] = mk(1, 1, 0, 1, 2'b00, 4'd3,  0, 0, '0);
    tbl[16] = mk(1, 0, 0, 0, 2'b00, 4'd3,  0, 1, '0);

    applyStimulus(0, 1, 1, 0, 0, 2'b00, 4'd0);
    applyStimulus(0, 1, 1, 0, 0, 2'b00, 4'd0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, tbl[i].en, tbl[i].rco, tbl[i].load, tbl[i].ready, tbl[i].modo, tbl[i].q);
      checkOutput("tbl_count", 32'(COUNT), 32'(tbl[i].exp_count));
      checkOutput("tbl_valid", 32'(ev_if.EV_VALID), 32'(tbl[i].exp_count != 0));
      if (tbl[i].chk_data)
        checkOutput("tbl_data", 32'(ev_if.EV_DATA), 32'(tbl[i].exp_data));
    end

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 2'b10, 4'(i));
      applyStimulus(1, 1, 0, 0, 0, 2'b10, 4'(i));
    end
    checkOutput("ovf_count", 32'(COUNT), 32'd8);
    checkOutput("ovf_flag", 32'(OVERFLOW), 32'd1);
    checkOutput("ovf_drops", 32'(DROPS), DROP_EN ? 32'd2 : 32'd0);

    applyStimulus(1, 1, 1, 0, 1, 2'b01, 4'd9);
    checkOutput("full_pushpop_count", 32'(COUNT), 32'd8);
    checkOutput("full_pushpop_drops", 32'(DROPS), DROP_EN ? 32'd2 : 32'd0);

    for (int i = 0; i < 8; i++)
      applyStimulus(1, 1, 0, 0, 1, 2'b00, 4'd0);
    checkOutput("drained_count", 32'(COUNT), 32'd0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 2'b00, 4'(i));
      applyStimulus(1, 1, 0, 0, 0, 2'b00, 4'(i));
    end
    applyStimulus(0, 1, 1, 0, 1, 2'b00, 4'd5);
    checkOutput("rst_count", 32'(COUNT), 32'd0);
    checkOutput("rst_ovf", 32'(OVERFLOW), 32'd0);
    checkOutput("rst_valid", 32'(ev_if.EV_VALID), 32'd0);
    applyStimulus(1, 1, 1, 0, 0, 2'b00, 4'd5);
    applyStimulus(1, 1, 1, 0, 0, 2'b00, 4'd5);
    checkOutput("rst_level_high_count", 32'(COUNT), 32'd0);

    for (int i = 0; i < 300; i++)
      applyStimulus(1, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
